// File: rtl/hwag_spi_pkg.sv
// Shared types and constants for the hwag SPI-slave register bridge.
package hwag_spi_pkg;

  // Frame decoder states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_DROP
  } state_e;

  // Command byte layout.
  localparam int          CMD_RD_BIT   = 7;
  localparam int          CMD_INC_BIT  = 6;
  localparam logic [7:0]  CMD_RSV_MASK = 8'h3F;

  // CMD and ADDR phases are always one byte long.
  localparam int          BYTE_BITS    = 8;

endpackage

// File: rtl/hwag_spi_sync.sv
// Multi-stage synchroniser for one SPI pin, with rise/fall pulses on the
// synchronised level. Pulses are combinational from the last two flops.
module hwag_spi_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw pin through the sync chain and keep the previous level.
  always_ff @(posedge clk) begin
    // NOTE: every register here gets a defined value on reset so the pulse
    // outputs cannot fire from X or from a pre-reset level.
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, regardless of statement order.
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/hwag_spi_bridge.sv
// SPI-slave (mode 0) front end that masters the hwag SSRAM register bus.
// Frame: CMD byte, ADDR byte, then any number of DATA_W-bit words.
module hwag_spi_bridge
  import hwag_spi_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int RD_LAT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              ssram_we,
  output logic              ssram_re,
  output logic [ADDR_W-1:0] ssram_addr,
  output logic [DATA_W-1:0] ssram_wdata,
  input  logic [DATA_W-1:0] ssram_rdata,
  output logic              ssram_data_oe,
  output logic              frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam int                LAT_W    = $clog2(RD_LAT + 2);
  localparam logic [CNT_W-1:0]  BYTE_LEN = CNT_W'(BYTE_BITS);
  localparam logic [CNT_W-1:0]  WORD_LEN = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  PREF_BIT = CNT_W'(8);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(RD_LAT + 1);

  // Synchronised pin events
  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q,  w_cs_rise,  w_cs_fall;
  logic w_mosi,  w_mosi_rise, w_mosi_fall;
  logic w_unused;

  // Control state and datapath registers
  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc, w_unit_len;
  logic              w_bit_in, w_unit_done, w_err;
  logic [7:0]        w_byte;
  logic [ADDR_W-1:0] w_inc;
  logic              r_rd, r_inc;
  logic [DATA_W-1:0] r_rx, r_tx, r_hold, r_wdata;
  logic [ADDR_W-1:0] r_addr;
  logic [LAT_W-1:0]  r_lat;
  logic              r_we, r_re, r_err;

  hwag_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .i_d(spi_sck),
    .o_q(w_sck_q), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  hwag_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .i_d(spi_cs_n),
    .o_q(w_cs_q), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  hwag_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .i_d(spi_mosi),
    .o_q(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
  );

  // Levels/edges the bridge has no use for.
  assign w_unused = &{1'b0, w_sck_q, w_cs_q, w_mosi_rise, w_mosi_fall};

  // Byte as it stands once the bit sampled this cycle is shifted in.
  assign w_byte = {r_rx[6:0], w_mosi};
  assign w_inc  = {{(ADDR_W-1){1'b0}}, r_inc};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, bit counting and frame-error detection.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_bit_in    = w_sck_rise &&
                  (r_state inside {ST_CMD, ST_ADDR, ST_WR_DATA, ST_RD_DATA});
    w_unit_len  = (r_state inside {ST_CMD, ST_ADDR}) ? BYTE_LEN : WORD_LEN;
    w_cnt_inc   = r_cnt + CNT_W'(1);
    w_unit_done = w_bit_in && (w_cnt_inc == w_unit_len);
    w_cnt_nxt   = w_unit_done ? '0 : (w_bit_in ? w_cnt_inc : r_cnt);

    case (r_state)
      ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_unit_done) begin
          if ((w_byte & CMD_RSV_MASK) != 8'h00) begin
            w_state_nxt = ST_DROP;
            w_err       = 1'b1;
          end else begin
            w_state_nxt = ST_ADDR;
          end
        end
      end
      ST_ADDR: if (w_unit_done) w_state_nxt = r_rd ? ST_RD_DATA : ST_WR_DATA;
      default: ;
    endcase

    // Deselect ends any frame; the bit sampled this same cycle counts first,
    // so only a genuinely partial unit is reported as an abort.
    if (w_cs_rise && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      if (r_state != ST_DROP && w_cnt_nxt != '0) w_err = 1'b1;
    end
  end

  // Shift registers, address, bus strobes and read-latency tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_rd    <= 1'b0;
      r_inc   <= 1'b0;
      r_rx    <= '0;
      r_tx    <= '0;
      r_hold  <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_lat   <= '0;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_err <= w_err;

      // Post-write increment, after the strobe cycle so addr was stable.
      if (r_we) r_addr <= r_addr + w_inc;

      // Capture read data RD_LAT cycles after the read strobe.
      if (r_lat == LAT_W'(1)) begin
        r_hold <= ssram_rdata;
        r_lat  <= '0;
      end else if (r_lat != '0) begin
        r_lat <= r_lat - LAT_W'(1);
      end

      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        r_tx  <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end

      if (w_bit_in) begin
        r_rx <= {r_rx[DATA_W-2:0], w_mosi};
        case (r_state)
          ST_CMD: if (w_unit_done) begin
            r_rd  <= w_byte[CMD_RD_BIT];
            r_inc <= w_byte[CMD_INC_BIT];
          end
          ST_ADDR: if (w_unit_done) begin
            r_addr <= ADDR_W'(w_byte);
            if (r_rd) begin
              r_re  <= 1'b1;
              r_lat <= LAT_LOAD;
            end
          end
          ST_WR_DATA: if (w_unit_done) begin
            r_we    <= 1'b1;
            r_wdata <= {r_rx[DATA_W-2:0], w_mosi};
          end
          ST_RD_DATA: if (w_cnt_inc == PREF_BIT) begin
            // Prefetch the next word half-way through the current one.
            r_addr <= r_addr + w_inc;
            r_re   <= 1'b1;
            r_lat  <= LAT_LOAD;
          end
          default: ;
        endcase
      end

      // Word start (count at zero) loads fresh data; otherwise shift out.
      if (r_state == ST_RD_DATA && w_sck_fall) begin
        if (r_cnt == '0) r_tx <= r_hold;
        else             r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi_miso_oe   = (r_state == ST_RD_DATA);
  assign spi_miso      = spi_miso_oe & r_tx[DATA_W-1];
  assign ssram_we      = r_we;
  assign ssram_re      = r_re;
  assign ssram_addr    = r_addr;
  assign ssram_wdata   = r_wdata;
  assign ssram_data_oe = r_we;
  assign frame_err     = r_err;

endmodule

// File: tb/tb_hwag_spi_bridge.sv
// Self-checking bench for hwag_spi_bridge: a pin-level SPI host, a ROM-style
// register model behind the bus, and a frame-level expectation model.
module tb_hwag_spi_bridge;

  localparam int H = 8;  // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic        ssram_we, ssram_re, ssram_data_oe, frame_err;
  logic [7:0]  ssram_addr;
  logic [15:0] ssram_wdata;
  logic [15:0] ssram_rdata = 16'h0;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  hwag_spi_bridge dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .ssram_we(ssram_we), .ssram_re(ssram_re),
    .ssram_addr(ssram_addr), .ssram_wdata(ssram_wdata),
    .ssram_rdata(ssram_rdata), .ssram_data_oe(ssram_data_oe),
    .frame_err(frame_err)
  );

  // Register file model: one-cycle read latency, contents set by the bench.
  logic [15:0] rom [0:255];
  always @(posedge clk) if (ssram_re) ssram_rdata <= rom[ssram_addr];

  // Bus monitor
  typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
  wr_t        we_q[$];
  logic [7:0] re_q[$];
  int  err_pulses = 0, err_long = 0, oe_viol = 0, both_viol = 0, miso_viol = 0;
  bit  oe_seen = 1'b0;
  logic err_d = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      if (ssram_we) we_q.push_back('{ssram_addr, ssram_wdata});
      if (ssram_re) re_q.push_back(ssram_addr);
      if (ssram_data_oe !== ssram_we) oe_viol++;
      if (ssram_we && ssram_re) both_viol++;
      if (!spi_miso_oe && spi_miso) miso_viol++;
      if (spi_miso_oe) oe_seen = 1'b1;
      if (frame_err) err_pulses++;
      if (frame_err && err_d) err_long++;
      err_d = frame_err;
    end else begin
      err_d = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    we_q.delete();
    re_q.delete();
    err_pulses = 0;
    oe_seen    = 1'b0;
    tick(1);
  endtask

  // One SPI bit: set MOSI in the low half, sample MISO just before the rise.
  task automatic bit_x(input logic mo, input bit cs_at_rise, output logic mi);
    spi_mosi = mo;
    tick(H);
    mi = spi_miso;
    spi_sck = 1'b1;
    if (cs_at_rise) spi_cs_n = 1'b1;
    tick(H);
    spi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) bit_x(b[i], 1'b0, d);
  endtask

  task automatic word_x(input logic [15:0] w, input bit cs_last, output logic [15:0] r);
    logic d;
    for (int i = 15; i >= 0; i--) begin
      bit_x(w[i], cs_last && (i == 0), d);
      r[i] = d;
    end
  endtask

  task automatic frame_end();
    tick(H);
    spi_cs_n = 1'b1;
    tick(2 * H);
  endtask

  function automatic logic [7:0] addr_k(input logic [7:0] a, input bit inc, input int k);
    return inc ? 8'(int'(a) + k) : a;
  endfunction

  // Complete frame with expectations derived from the frame's own fields.
  task automatic run_frame(input bit rd, input bit inc, input logic [7:0] a,
                           input int n, input logic [15:0] wd [4]);
    logic [15:0] got;
    clear_mon();
    spi_cs_n = 1'b0;
    send_byte({rd, inc, 6'b0});
    send_byte(a);
    for (int k = 0; k < n; k++) begin
      word_x(rd ? 16'h0 : wd[k], 1'b0, got);
      if (rd) check("rd_word", {16'h0, got}, {16'h0, rom[addr_k(a, inc, k)]});
    end
    frame_end();
    if (rd) begin
      check("re_cnt", re_q.size(), n + 1);
      for (int k = 0; k <= n && k < re_q.size(); k++)
        check("re_addr", {24'h0, re_q[k]}, {24'h0, addr_k(a, inc, k)});
      check("we_cnt_rd", we_q.size(), 0);
    end else begin
      check("we_cnt", we_q.size(), n);
      for (int k = 0; k < n && k < we_q.size(); k++) begin
        check("we_addr", {24'h0, we_q[k].addr}, {24'h0, addr_k(a, inc, k)});
        check("we_data", {16'h0, we_q[k].data}, {16'h0, wd[k]});
      end
      check("re_cnt_wr", re_q.size(), 0);
    end
    check("frame_err_clean", err_pulses, 0);
  endtask

  function automatic logic [31:0] all_outs();
    return {5'h0, ssram_we, ssram_re, ssram_addr, ssram_wdata,
            ssram_data_oe, spi_miso, spi_miso_oe, frame_err};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] wd [4];
    logic [15:0] got;
    logic        d;

    for (int i = 0; i < 256; i++) rom[i] = 16'(i * 3);

    // Reset state
    tick(4);
    check("reset_outputs", all_outs(), 32'h0);
    rst = 1'b1;
    tick(4);

    // Single write, no increment
    wd = '{16'h0003, 16'h0, 16'h0, 16'h0};
    run_frame(1'b0, 1'b0, 8'h00, 1, wd);

    // Auto-increment write across 0x3F -> 0x40
    wd = '{16'h0007, 16'h0001, 16'h0, 16'h0};
    run_frame(1'b0, 1'b1, 8'h3F, 2, wd);

    // Auto-increment read wrapping 0xFF -> 0x00
    run_frame(1'b1, 1'b1, 8'hFF, 2, wd);

    // Abort after 9 bits of a write word, then a normal frame
    clear_mon();
    spi_cs_n = 1'b0;
    send_byte(8'h00);
    send_byte(8'h10);
    for (int i = 0; i < 9; i++) bit_x(1'b1, 1'b0, d);
    frame_end();
    check("abort_we_cnt", we_q.size(), 0);
    check("abort_err", err_pulses, 1);
    wd = '{16'hBEEF, 16'h0, 16'h0, 16'h0};
    run_frame(1'b0, 1'b0, 8'h11, 1, wd);

    // Reserved command bits set: whole frame dropped
    clear_mon();
    spi_cs_n = 1'b0;
    send_byte(8'h05);
    send_byte(8'h20);
    send_byte(8'hFF);
    send_byte(8'hFF);
    frame_end();
    check("drop_err", err_pulses, 1);
    check("drop_we", we_q.size(), 0);
    check("drop_re", re_q.size(), 0);
    check("drop_oe", {31'h0, oe_seen}, 32'h0);

    // Deselect together with the final write bit: write completes cleanly
    clear_mon();
    spi_cs_n = 1'b0;
    send_byte(8'h00);
    send_byte(8'h22);
    word_x(16'hA5C3, 1'b1, got);
    tick(2 * H);
    check("edge_we_cnt", we_q.size(), 1);
    if (we_q.size() > 0) begin
      check("edge_we_addr", {24'h0, we_q[0].addr}, 32'h22);
      check("edge_we_data", {16'h0, we_q[0].data}, 32'hA5C3);
    end
    check("edge_err", err_pulses, 0);

    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);

    // Reset in the middle of a read word
    clear_mon();
    spi_cs_n = 1'b0;
    send_byte(8'hC0);
    send_byte(8'h40);
    for (int i = 0; i < 5; i++) bit_x(1'b0, 1'b0, d);
    rst = 1'b0;
    tick(1);
    check("midrst_outputs", all_outs(), 32'h0);
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(2 * H);
    run_frame(1'b1, 1'b1, 8'h40, 2, wd);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < 4; k++) wd[k] = 16'($urandom);
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), int'($urandom_range(0, 3)), wd);
    end

    // Whole-run bus invariants
    check("oe_equals_we", oe_viol, 0);
    check("we_re_exclusive", both_viol, 0);
    check("miso_zero_when_off", miso_viol, 0);
    check("err_single_cycle", err_long, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
